load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - CPU-side initiator for the data memory: accepts one load/store from the execute stage via valid/ready.
// - Drives the memory's address/data/strobe/size port, checks alignment and range, and returns a sized load result.
// - Load results are sign- or zero-extended; the memory is big-endian (lowest address = MS byte).
// - Sits between the EX/MEM pipeline register and the 64-byte data memory.
// PARAMETERS
// - MEM_BYTES  64  addressable bytes; addresses >= MEM_BYTES are out of range
// PORTS
// - clk          in   1   clock, all state on posedge
// - reset        in   1   asynchronous, active-high
// - req_valid    in   1   request present
// - req_ready    out  1   unit idle, request accepted when valid&ready at posedge
// - req_write    in   1   1=store, 0=load
// - req_size     in   2   00 byte, 01 half, 10 word, 11 double (memory wordSize encoding)
// - req_unsigned in   1   load zero-extends (LBU/LHU/LWU); ignored for stores/double
// - req_addr     in   64  byte address
// - req_wdata    in   64  store data, right-justified
// - resp_valid   out  1   one-cycle pulse, response ready
// - resp_err     out  1   misaligned/out-of-range; qualified by resp_valid
// - resp_rdata   out  64  extended load data; 0 for stores/errors
// - mem_addr     out  64  to memory Mem_Addr
// - mem_wdata    out  64  to memory Write_Data
// - mem_read     out  1   to memory MemRead
// - mem_write    out  1   to memory MemWrite
// - mem_size     out  2   to memory wordSize
// - mem_rdata    in   64  from memory Read_Data (combinational)
// BEHAVIOUR
// - FSM: IDLE -> ACCESS -> RESP -> IDLE; SPLIT replaces ACCESS for misaligned requests (see CONFIGURATION).
// - req_ready = (state==IDLE); the request is registered on accept.
// - Reset: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0.
// - Range check: err if addr + nbytes > MEM_BYTES (nbytes=1/2/4/8), computed at full width.
// - Alignment: half addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; byte always aligned.
// - ACCESS (aligned, in range), accept at cycle N:
//   - Cycle N+1 drives the mem_* port with req size/addr/wdata and mem_read or mem_write=1.
//   - Loads capture mem_rdata at the end of N+1; stores are written by the memory at the end of N+1.
// - Error case: no mem strobe in N+1; resp_err=1.
// - RESP at N+2: resp_valid=1 for exactly one cycle; resp_rdata/resp_err update then and hold until the next response.
// - Outside ACCESS/SPLIT, mem_read=mem_write=0 and mem_addr/mem_wdata/mem_size=0.
// - Extension: the unit takes the low 8*nbytes bits and re-extends them itself; the memory's own extension is discarded.
//   - Signed: replicate bit 8*nbytes-1. Unsigned: zero-fill.
// - Requests arriving while busy are not accepted; no queueing.
// - Reset mid-operation: immediate return to IDLE, strobes drop asynchronously, no response.
//   - Bytes already written by a split store remain (no rollback).
// CONFIGURATION
// - MISALIGN_SPLIT_EN defined:
//   - A misaligned, in-range request enters SPLIT and issues nbytes byte accesses (mem_size=00), one per cycle, at addr+0 .. addr+nbytes-1.
//   - Store byte k gets wdata[8*(nbytes-k)-1 -: 8] (MS first).
//   - Load shifts acc = {acc[55:0], mem_rdata[7:0]} each cycle.
//   - resp_valid at N+nbytes+1, resp_err=0.
// - Undefined: a misaligned request is an error; no mem strobes; response at N+2 with resp_err=1.
// TESTING
// - Reset with req_valid=1 -> req_ready=1, resp_valid=0, mem_read=mem_write=0, resp_rdata=0.
// - SD 0x0102030405060708 @0x08, then LD @0x08 -> mem_write only in N+1; resp N+2; rdata=0x0102030405060708.
// - SB 0x80 @0x10; LB -> 0xFFFFFFFFFFFFFF80; LBU -> 0x0000000000000080; SH 0x7FFF @0x12, LH -> 0x7FFF.
// - LW @0x05 undefined macro -> no strobe, resp N+2 err=1; defined, after SW 0xDEADBEEF @0x05 -> 4 byte strobes, resp N+5, rdata=0xFFFFFFFFDEADBEEF.
// - LD @0x40 and LW @0x3E -> err=1, no strobes; LD @0x38 -> err=0 (last legal double).
// - Reset asserted in 2nd cycle of a split SD @0x01 -> mem_write=0 immediately, IDLE, no resp_valid; byte 0x01 keeps new value.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : load_store_unit                                                   |
// | Desc   : Accepts one load/store from the execute stage and drives the data |
// |          memory port. It checks alignment and range, and returns a        |
// |          sign- or zero-extended load result from big-endian memory.        |
// |          Defining MISALIGN_SPLIT_EN splits misaligned requests into byte   |
// |          accesses.                                                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_SPLIT  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_err;
  logic        r_resp_err;
  logic [63:0] r_resp_rdata;

  logic [3:0]  w_nbytes;
  logic [64:0] w_end;
  logic        w_range_err;
  logic        w_misaligned;
  logic        w_req_err;
  logic        w_req_split;
  logic [63:0] w_load_raw;
  logic [63:0] w_load_ext;

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   extend = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   extend = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   extend = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

  // Range is checked one bit wider than the address so a wrap near 2^64 still errors.
  assign w_nbytes    = 4'd1 << req_size;
  assign w_end       = {1'b0, req_addr} + {61'd0, w_nbytes};
  assign w_range_err = w_end > 65'(MEM_BYTES);

  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  logic [2:0]  r_cnt;
  logic [55:0] r_acc;
  logic [3:0]  w_r_nbytes;
  logic [2:0]  w_last;
  logic [2:0]  w_rem;
  logic [7:0]  w_split_byte;

  assign w_req_err    = w_range_err;
  assign w_req_split  = w_misaligned && !w_range_err;
  assign w_r_nbytes   = 4'd1 << r_size;
  assign w_last       = 3'(w_r_nbytes - 4'd1);
  // Byte k of a split store is taken most-significant first.
  assign w_rem        = w_last - r_cnt;
  assign w_split_byte = 8'(r_wdata >> {w_rem, 3'b000});
  assign w_load_raw   = (r_state == S_SPLIT) ? {r_acc, mem_rdata[7:0]} : mem_rdata;
`else
  assign w_req_err    = w_range_err || w_misaligned;
  assign w_req_split  = 1'b0;
  assign w_load_raw   = mem_rdata;
`endif

  assign w_load_ext = extend(w_load_raw, r_size, r_unsigned);
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = 64'd0;
    mem_wdata  = 64'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = 2'b00;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_split ? S_SPLIT : S_ACCESS;
      end
      S_ACCESS: begin
        if (!r_err) begin
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
          mem_size  = r_size;
          mem_read  = !r_write;
          mem_write = r_write;
        end
        w_next = S_RESP;
      end
`ifdef MISALIGN_SPLIT_EN
      S_SPLIT: begin
        mem_addr  = r_addr + 64'(r_cnt);
        mem_wdata = {56'd0, w_split_byte};
        mem_read  = !r_write;
        mem_write = r_write;
        if (r_cnt == w_last) w_next = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      r_err        <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 64'd0;
`ifdef MISALIGN_SPLIT_EN
      r_cnt        <= 3'd0;
      r_acc        <= 56'd0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_err      <= w_req_err;
`ifdef MISALIGN_SPLIT_EN
        r_cnt      <= 3'd0;
        r_acc      <= 56'd0;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      if (r_state == S_SPLIT) begin
        r_cnt <= r_cnt + 3'd1;
        r_acc <= {r_acc[47:0], mem_rdata[7:0]};
      end
`endif
      // The response is latched on the last access cycle so it appears with resp_valid.
      if (w_next == S_RESP) begin
        r_resp_err   <= r_err;
        r_resp_rdata <= (r_write || r_err) ? 64'd0 : w_load_ext;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Directed bench for load_store_unit with a 64-byte big-endian memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [63:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read with its own sign extension (which the unit must discard).
  logic [7:0] mem [0:63];

  always_comb begin
    logic [63:0] raw;
    int nb;
    nb  = 1 << mem_size;
    raw = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i < nb) raw = {raw[55:0], mem[6'(mem_addr + 64'(i))]};
    case (mem_size)
      2'b00:   mem_rdata = {{56{raw[7]}},  raw[7:0]};
      2'b01:   mem_rdata = {{48{raw[15]}}, raw[15:0]};
      2'b10:   mem_rdata = {{32{raw[31]}}, raw[31:0]};
      default: mem_rdata = raw;
    endcase
    if (!mem_read) mem_rdata = 64'd0;
  end

  always @(posedge clk) begin
    int nb;
    nb = 1 << mem_size;
    if (mem_write)
      for (int i = 0; i < 8; i++)
        if (i < nb) mem[6'(mem_addr + 64'(i))] <= mem_wdata[8*(nb-1-i) +: 8];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request; counts strobes and the cycle (after accept) at which resp_valid appears.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [63:0] a, input logic [63:0] d, input int exp_lat,
                     input logic exp_err, input logic [63:0] exp_rd, input int exp_strobes);
    int n_wr, n_rd, lat;
    n_wr = 0; n_rd = 0; lat = 0;
    @(negedge clk);
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_write) n_wr++;
      if (mem_read) n_rd++;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " err"}, 64'(resp_err), 64'(exp_err));
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " writes"}, 64'(n_wr), w ? 64'(exp_strobes) : 64'd0);
    check({tag, " reads"}, 64'(n_rd), w ? 64'd0 : 64'(exp_strobes));
    @(negedge clk);
    check({tag, " pulse"}, 64'(resp_valid), 64'd0);
    check({tag, " hold"}, resp_rdata, exp_rd);
  endtask

  initial begin
    int n_resp;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    #12;
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_err", 64'(resp_err), 64'd0);
    check("rst mem_read", 64'(mem_read), 64'd0);
    check("rst mem_write", 64'(mem_write), 64'd0);
    check("rst rdata", resp_rdata, 64'd0);
    check("rst mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;

    txn("SD0 0x00", 1, 2'b11, 0, 64'h00, 64'd0, 2, 0, 64'd0, 1);
`ifdef MISALIGN_SPLIT_EN
    txn("SW 0x05", 1, 2'b10, 0, 64'h05, 64'hDEADBEEF, 5, 0, 64'd0, 4);
    txn("LW 0x05", 0, 2'b10, 0, 64'h05, 64'd0, 5, 0, 64'hFFFFFFFFDEADBEEF, 4);
    txn("LHU 0x07", 0, 2'b01, 1, 64'h07, 64'd0, 3, 0, 64'h000000000000BEEF, 2);
    txn("LBU 0x05", 0, 2'b00, 1, 64'h05, 64'd0, 2, 0, 64'h00000000000000DE, 1);
`else
    txn("LW 0x05", 0, 2'b10, 0, 64'h05, 64'd0, 2, 1, 64'd0, 0);
    txn("SH 0x03", 1, 2'b01, 0, 64'h03, 64'h1234, 2, 1, 64'd0, 0);
`endif
    txn("SD 0x08", 1, 2'b11, 0, 64'h08, 64'h0102030405060708, 2, 0, 64'd0, 1);
    txn("LD 0x08", 0, 2'b11, 0, 64'h08, 64'd0, 2, 0, 64'h0102030405060708, 1);
    txn("LB 0x09", 0, 2'b00, 0, 64'h09, 64'd0, 2, 0, 64'h02, 1);
    txn("SB 0x10", 1, 2'b00, 0, 64'h10, 64'h123456789ABCDE80, 2, 0, 64'd0, 1);
    txn("LB 0x10", 0, 2'b00, 0, 64'h10, 64'd0, 2, 0, 64'hFFFFFFFFFFFFFF80, 1);
    txn("LBU 0x10", 0, 2'b00, 1, 64'h10, 64'd0, 2, 0, 64'h0000000000000080, 1);
    txn("SH 0x12", 1, 2'b01, 0, 64'h12, 64'h7FFF, 2, 0, 64'd0, 1);
    txn("LH 0x12", 0, 2'b01, 0, 64'h12, 64'd0, 2, 0, 64'h7FFF, 1);
    txn("SH 0x14", 1, 2'b01, 0, 64'h14, 64'hAAAA8001, 2, 0, 64'd0, 1);
    txn("LH 0x14", 0, 2'b01, 0, 64'h14, 64'd0, 2, 0, 64'hFFFFFFFFFFFF8001, 1);
    txn("LHU 0x14", 0, 2'b01, 1, 64'h14, 64'd0, 2, 0, 64'h0000000000008001, 1);
    txn("SW 0x18", 1, 2'b10, 0, 64'h18, 64'h55555555DEADBEEF, 2, 0, 64'd0, 1);
    txn("LW 0x18", 0, 2'b10, 0, 64'h18, 64'd0, 2, 0, 64'hFFFFFFFFDEADBEEF, 1);
    txn("LWU 0x18", 0, 2'b10, 1, 64'h18, 64'd0, 2, 0, 64'h00000000DEADBEEF, 1);
    txn("LB 0x18", 0, 2'b00, 0, 64'h18, 64'd0, 2, 0, 64'hFFFFFFFFFFFFFFDE, 1);
    txn("LD 0x40", 0, 2'b11, 0, 64'h40, 64'd0, 2, 1, 64'd0, 0);
    txn("LW 0x3E", 0, 2'b10, 0, 64'h3E, 64'd0, 2, 1, 64'd0, 0);
    txn("SB 0x40", 1, 2'b00, 0, 64'h40, 64'h11, 2, 1, 64'd0, 0);
    txn("LB wrap", 0, 2'b00, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 2, 1, 64'd0, 0);
    txn("SD 0x38", 1, 2'b11, 0, 64'h38, 64'h1122334455667788, 2, 0, 64'd0, 1);
    txn("LD 0x38", 0, 2'b11, 0, 64'h38, 64'd0, 2, 0, 64'h1122334455667788, 1);

    // Reset during the access cycle of an aligned store: strobe drops, nothing written.
    txn("SD0 0x20", 1, 2'b11, 0, 64'h20, 64'd0, 2, 0, 64'd0, 1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_addr = 64'h20;
    req_wdata = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("midrst strobe before", 64'(mem_write), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst strobe after", 64'(mem_write), 64'd0);
    check("midrst mem_addr", mem_addr, 64'd0);
    check("midrst ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    n_resp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    check("midrst no resp", 64'(n_resp), 64'd0);
    txn("LBU 0x20", 0, 2'b00, 1, 64'h20, 64'd0, 2, 0, 64'd0, 1);

`ifdef MISALIGN_SPLIT_EN
    // Reset in the second byte cycle of a split store: first byte stays written.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_addr = 64'h01;
    req_wdata = 64'hA1A2A3A4A5A6A7A8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("split1 addr", mem_addr, 64'h01);
    check("split1 wdata", mem_wdata, 64'hA1);
    @(posedge clk);
    #1;
    check("split2 strobe", 64'(mem_write), 64'd1);
    check("split2 addr", mem_addr, 64'h02);
    check("split2 size", 64'(mem_size), 64'd0);
    check("split2 wdata", mem_wdata, 64'hA2);
    reset = 1'b1;
    #1;
    check("splitrst strobe", 64'(mem_write), 64'd0);
    check("splitrst ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    n_resp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    check("splitrst no resp", 64'(n_resp), 64'd0);
    txn("LB 0x01", 0, 2'b00, 0, 64'h01, 64'd0, 2, 0, 64'hFFFFFFFFFFFFFFA1, 1);
    txn("LBU 0x02", 0, 2'b00, 1, 64'h02, 64'd0, 2, 0, 64'd0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
